// File: rtl/downscale_2x2_box.sv
// 2x2 box-filter downscaler on an AXI-Stream style pixel stream.
// Even rows are folded into horizontal pair sums kept in a flop line buffer; odd rows emit rounded averages.
module downscale_2x2_box #(
  parameter int D_WIDTH    = 8,
  parameter int LB_A_WIDTH = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  input  logic               up_tlast,
  input  logic               up_tuser,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  output logic               down_tlast,
  output logic               down_tuser,
  input  logic               down_ready
);

  localparam int LB_DEPTH = 2 ** LB_A_WIDTH;
  localparam int HS_W     = D_WIDTH + 1;
  localparam int TOT_W    = D_WIDTH + 2;

  // Max total is 4*(2^D-1); adding 2 still fits TOT_W bits, so the quotient fits D_WIDTH.
  function automatic logic [D_WIDTH-1:0] round_avg4(input logic [TOT_W-1:0] total);
    logic [TOT_W-1:0] biased;
    biased     = total + TOT_W'(2);
    round_avg4 = biased[TOT_W-1:2];
  endfunction

  logic                  col_par;
  logic                  row_par;
  logic [LB_A_WIDTH-1:0] col_idx;
  logic [D_WIDTH-1:0]    hold;
  logic                  sof_pend;
  logic [HS_W-1:0]       line_buf [LB_DEPTH];

  logic                  accept;
  logic                  pop;
  logic                  eff_col_par;
  logic                  eff_row_par;
  logic [LB_A_WIDTH-1:0] eff_col_idx;
  logic [HS_W-1:0]       hs;
  logic [HS_W-1:0]       lb_rd;
  logic [TOT_W-1:0]      total;
  logic                  emit;
  logic                  lb_wr;

  assign up_ready = ~down_valid | down_ready;
  assign accept   = up_valid & up_ready;
  assign pop      = down_valid & down_ready;

  // A start-of-frame pixel is always column 0 of row 0, whatever the state says.
  assign eff_col_par = col_par & ~up_tuser;
  assign eff_row_par = row_par & ~up_tuser;
  assign eff_col_idx = up_tuser ? '0 : col_idx;

  assign lb_rd = line_buf[eff_col_idx];
  assign hs    = {1'b0, hold} + {1'b0, up_data};
  assign total = {1'b0, lb_rd} + {1'b0, hs};
  assign emit  = accept & eff_col_par & eff_row_par;
  assign lb_wr = accept & eff_col_par & ~eff_row_par;

  always_ff @(posedge clk) begin
    if (lb_wr) line_buf[eff_col_idx] <= hs;
  end

  // ---- single register stage: stream position state and output beat ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_par    <= 1'b0;
      row_par    <= 1'b0;
      col_idx    <= '0;
      hold       <= '0;
      sof_pend   <= 1'b0;
      down_valid <= 1'b0;
      down_data  <= '0;
      down_tlast <= 1'b0;
      down_tuser <= 1'b0;
    end else begin
      if (accept) begin
        row_par <= eff_row_par;
        if (!eff_col_par) begin
          hold    <= up_data;
          col_par <= 1'b1;
          col_idx <= eff_col_idx;
        end else begin
          col_par <= 1'b0;
          col_idx <= eff_col_idx + LB_A_WIDTH'(1);
        end
        if (up_tlast) begin
          col_par <= 1'b0;
          col_idx <= '0;
          row_par <= ~eff_row_par;
        end
        if (emit) sof_pend <= 1'b0;
        else if (up_tuser) sof_pend <= 1'b1;
      end

      if (emit) begin
        down_valid <= 1'b1;
        down_data  <= round_avg4(total);
        down_tlast <= up_tlast;
        down_tuser <= sof_pend;
      end else if (pop) begin
        down_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_downscale_2x2_box.sv
// Directed bench for downscale_2x2_box: hand-computed frames, stalls, resync and async reset.
module tb_downscale_2x2_box;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] up_data = '0;
  logic       up_valid = 1'b0;
  logic       up_tlast = 1'b0;
  logic       up_tuser = 1'b0;
  logic       up_ready;
  logic [7:0] down_data;
  logic       down_valid;
  logic       down_tlast;
  logic       down_tuser;
  logic       down_ready = 1'b1;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t q[$];
  int    n_vec = 0;
  int    n_err = 0;

  downscale_2x2_box #(.D_WIDTH(8), .LB_A_WIDTH(9)) dut (
    .clk(clk), .rst(rst),
    .up_data(up_data), .up_valid(up_valid), .up_tlast(up_tlast), .up_tuser(up_tuser),
    .up_ready(up_ready),
    .down_data(down_data), .down_valid(down_valid), .down_tlast(down_tlast),
    .down_tuser(down_tuser), .down_ready(down_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && down_valid && down_ready) q.push_back('{d: down_data, l: down_tlast, u: down_tuser});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_px(input logic [7:0] d, input logic l, input logic u);
    int waitc;
    up_valid = 1'b1;
    up_data  = d;
    up_tlast = l;
    up_tuser = u;
    waitc    = 0;
    forever begin
      @(negedge clk);
      if (up_ready) break;
      waitc++;
      if (waitc > 50) begin
        chk("accept_timeout", 32'(waitc), 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    up_valid = 1'b0;
    up_tlast = 1'b0;
    up_tuser = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic exp_beat(input string tag, input int idx, input logic [7:0] d,
                          input logic l, input logic u);
    if (idx < q.size()) begin
      chk({tag, "_data"}, 32'(q[idx].d), 32'(d));
      chk({tag, "_tlast"}, 32'(q[idx].l), 32'(l));
      chk({tag, "_tuser"}, 32'(q[idx].u), 32'(u));
    end else begin
      chk({tag, "_missing"}, 32'(q.size()), 32'(idx + 1));
    end
  endtask

  task automatic frame_4x2();
    send_px(8'd10, 1'b0, 1'b1);
    send_px(8'd20, 1'b0, 1'b0);
    send_px(8'd30, 1'b0, 1'b0);
    send_px(8'd40, 1'b1, 1'b0);
    send_px(8'd50, 1'b0, 1'b0);
    send_px(8'd60, 1'b0, 1'b0);
    send_px(8'd70, 1'b0, 1'b0);
    send_px(8'd81, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_up_ready", 32'(up_ready), 1);
    chk("rst_down_valid", 32'(down_valid), 0);
    chk("rst_down_data", 32'(down_data), 0);
    chk("rst_down_flags", 32'({down_tlast, down_tuser}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 4x2 frame with output latency checks
    q.delete();
    send_px(8'd10, 1'b0, 1'b1);
    send_px(8'd20, 1'b0, 1'b0);
    send_px(8'd30, 1'b0, 1'b0);
    send_px(8'd40, 1'b1, 1'b0);
    chk("even_row_no_out", 32'(down_valid), 0);
    send_px(8'd50, 1'b0, 1'b0);
    send_px(8'd60, 1'b0, 1'b0);
    chk("lat1_valid", 32'(down_valid), 1);
    chk("lat1_data", 32'(down_data), 35);
    chk("lat1_tuser", 32'(down_tuser), 1);
    send_px(8'd70, 1'b0, 1'b0);
    send_px(8'd81, 1'b1, 1'b0);
    chk("lat2_valid", 32'(down_valid), 1);
    chk("lat2_data", 32'(down_data), 55);
    chk("lat2_tlast", 32'(down_tlast), 1);
    drain();
    chk("f4x2_count", 32'(q.size()), 2);
    exp_beat("f4x2_o0", 0, 8'd35, 1'b0, 1'b1);
    exp_beat("f4x2_o1", 1, 8'd55, 1'b1, 1'b0);

    // 8x4 all-255 frame
    q.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        send_px(8'd255, c == 7, (r == 0) && (c == 0));
    drain();
    chk("sat_count", 32'(q.size()), 8);
    for (int i = 0; i < 8; i++)
      exp_beat($sformatf("sat_o%0d", i), i, 8'd255, (i % 4) == 3, i == 0);

    // Downstream stall after first output
    q.delete();
    send_px(8'd10, 1'b0, 1'b1);
    send_px(8'd20, 1'b0, 1'b0);
    send_px(8'd30, 1'b0, 1'b0);
    send_px(8'd40, 1'b1, 1'b0);
    send_px(8'd50, 1'b0, 1'b0);
    send_px(8'd60, 1'b0, 1'b0);
    down_ready = 1'b0;
    up_valid   = 1'b1;
    up_data    = 8'd70;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_up_ready", 32'(up_ready), 0);
      chk("stall_valid", 32'(down_valid), 1);
      chk("stall_data", 32'(down_data), 35);
    end
    @(posedge clk);
    #1;
    down_ready = 1'b1;
    send_px(8'd70, 1'b0, 1'b0);
    send_px(8'd81, 1'b1, 1'b0);
    drain();
    chk("stall_count", 32'(q.size()), 2);
    exp_beat("stall_o0", 0, 8'd35, 1'b0, 1'b1);
    exp_beat("stall_o1", 1, 8'd55, 1'b1, 1'b0);

    // 5-wide lines: the lone fifth pixel is dropped
    q.delete();
    send_px(8'd1, 1'b0, 1'b1);
    send_px(8'd2, 1'b0, 1'b0);
    send_px(8'd3, 1'b0, 1'b0);
    send_px(8'd4, 1'b0, 1'b0);
    send_px(8'd5, 1'b1, 1'b0);
    send_px(8'd5, 1'b0, 1'b0);
    send_px(8'd6, 1'b0, 1'b0);
    send_px(8'd7, 1'b0, 1'b0);
    send_px(8'd8, 1'b0, 1'b0);
    send_px(8'd9, 1'b1, 1'b0);
    drain();
    chk("odd_w_count", 32'(q.size()), 2);
    exp_beat("odd_w_o0", 0, 8'd4, 1'b0, 1'b1);
    exp_beat("odd_w_o1", 1, 8'd6, 1'b0, 1'b0);

    // New tuser mid-row1 resynchronises
    q.delete();
    send_px(8'd10, 1'b0, 1'b1);
    send_px(8'd20, 1'b0, 1'b0);
    send_px(8'd30, 1'b0, 1'b0);
    send_px(8'd40, 1'b1, 1'b0);
    send_px(8'd50, 1'b0, 1'b0);
    send_px(8'd60, 1'b0, 1'b0);
    send_px(8'd100, 1'b0, 1'b1);
    send_px(8'd100, 1'b0, 1'b0);
    send_px(8'd200, 1'b0, 1'b0);
    send_px(8'd200, 1'b1, 1'b0);
    send_px(8'd0, 1'b0, 1'b0);
    send_px(8'd0, 1'b0, 1'b0);
    send_px(8'd4, 1'b0, 1'b0);
    send_px(8'd4, 1'b1, 1'b0);
    drain();
    chk("resync_count", 32'(q.size()), 3);
    exp_beat("resync_o0", 0, 8'd35, 1'b0, 1'b1);
    exp_beat("resync_o1", 1, 8'd50, 1'b0, 1'b1);
    exp_beat("resync_o2", 2, 8'd102, 1'b1, 1'b0);

    // Asynchronous reset between edges with an output pending
    q.delete();
    down_ready = 1'b0;
    send_px(8'd10, 1'b0, 1'b1);
    send_px(8'd20, 1'b0, 1'b0);
    send_px(8'd30, 1'b0, 1'b0);
    send_px(8'd40, 1'b1, 1'b0);
    send_px(8'd50, 1'b0, 1'b0);
    send_px(8'd60, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(down_valid), 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(down_valid), 0);
    chk("arst_data", 32'(down_data), 0);
    chk("arst_flags", 32'({down_tlast, down_tuser}), 0);
    chk("arst_up_ready", 32'(up_ready), 1);
    rst = 1'b0;
    down_ready = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    frame_4x2();
    drain();
    chk("post_rst_count", 32'(q.size()), 2);
    exp_beat("post_rst_o0", 0, 8'd35, 1'b0, 1'b1);
    exp_beat("post_rst_o1", 1, 8'd55, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
